// File: rtl/vec_mem_sequencer.sv
// vec_mem_sequencer
//   Memory-stage controller between the EX/MEM register and a word-wide data
//   memory. Splits one scalar or vector load/store into word beats, stalls the
//   pipeline while the sequence runs, and assembles vector load data.
//   One request in flight at a time.
//
// Ports
//   clk, rst                 clock (posedge), async active-high reset
//   mem_read, mem_write      stage request (write wins if both are high)
//   vector_op                1 = VEC_W/WORD_W beats, 0 = single beat
//   addr, wdata, rd_idx      base word address, store data, dest register
//   stall, busy              pipeline hold, FSM not idle
//   mem_req/we/addr/wdata    memory beat request
//   mem_ready                beat accepted when mem_req & mem_ready
//   mem_rvalid, mem_rdata    read data, one cycle after each accepted read beat
//   done, rdata_valid        completion pulse, load data valid (loads only)
//   rdata, wb_idx            assembled load data, latched rd_idx
module vec_mem_sequencer #(
   parameter int VEC_W  = 192,
   parameter int WORD_W = 32,
   parameter int ADDR_W = 16,
   parameter int IDX_W  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              mem_read,
   input  logic              mem_write,
   input  logic              vector_op,
   input  logic [ADDR_W-1:0] addr,
   input  logic [VEC_W-1:0]  wdata,
   input  logic [IDX_W-1:0]  rd_idx,
   output logic              stall,
   output logic              busy,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [WORD_W-1:0] mem_wdata,
   input  logic              mem_ready,
   input  logic              mem_rvalid,
   input  logic [WORD_W-1:0] mem_rdata,
   output logic              done,
   output logic              rdata_valid,
   output logic [VEC_W-1:0]  rdata,
   output logic [IDX_W-1:0]  wb_idx
);

   localparam int NBEATS = VEC_W / WORD_W;
   localparam int CNT_W  = $clog2(NBEATS + 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   // Request snapshot taken in the accept cycle; the stage inputs are not
   // trusted afterwards.
   typedef struct packed {
      logic              is_wr;
      logic              vec;
      logic [ADDR_W-1:0] base;
      logic [VEC_W-1:0]  wdata;
      logic [IDX_W-1:0]  idx;
   } req_t;

   req_t             req_q, req_d;
   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] beat_q, beat_d;
   logic [CNT_W-1:0] rbeat_q, rbeat_d;
   logic [VEC_W-1:0] rdata_q, rdata_d;

   logic             req_in;
   logic [CNT_W-1:0] nbeats;
   logic             last_beat;
   logic             capture;
   logic [WORD_W-1:0] beat_word;

   assign req_in    = mem_read | mem_write;
   assign nbeats    = req_q.vec ? CNT_W'(NBEATS) : CNT_W'(1);
   assign last_beat = (beat_q == nbeats - CNT_W'(1));

   // Read returns are only meaningful while a load is sequencing; the count
   // guard keeps a stray extra rvalid from walking past the vector.
   assign capture = ((state_q == S_ISSUE) || (state_q == S_DRAIN)) &&
                    mem_rvalid && !req_q.is_wr && (rbeat_q < nbeats);

   // Store word select for the current beat.
   always_comb begin
      beat_word = '0;
      for (int k = 0; k < NBEATS; k++)
         if (beat_q == CNT_W'(k))
            beat_word = req_q.wdata[k*WORD_W +: WORD_W];
   end

   always_comb begin
      state_d = state_q;
      req_d   = req_q;
      beat_d  = beat_q;
      rbeat_d = rbeat_q;
      rdata_d = rdata_q;

      if (capture) begin
         for (int k = 0; k < NBEATS; k++)
            if (rbeat_q == CNT_W'(k))
               rdata_d[k*WORD_W +: WORD_W] = mem_rdata;
         rbeat_d = rbeat_q + CNT_W'(1);
      end

      case (state_q)
         S_IDLE: begin
            if (req_in) begin
               req_d.is_wr = mem_write;
               req_d.vec   = vector_op;
               req_d.base  = addr;
               req_d.wdata = wdata;
               req_d.idx   = rd_idx;
               beat_d      = '0;
               rbeat_d     = '0;
               rdata_d     = '0;
               state_d     = S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (mem_ready) begin
               beat_d = beat_q + CNT_W'(1);
               if (last_beat)
                  state_d = req_q.is_wr ? S_DONE : S_DRAIN;
            end
         end
         S_DRAIN: begin
            // Leave once the final return has been written this cycle.
            if (rbeat_d == nbeats)
               state_d = S_DONE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         req_q   <= '0;
         beat_q  <= '0;
         rbeat_q <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         req_q   <= req_d;
         beat_q  <= beat_d;
         rbeat_q <= rbeat_d;
         rdata_q <= rdata_d;
      end
   end

   // Stall covers the accept cycle combinationally; it is masked during reset
   // so every output reads zero while rst is high.
   assign stall = !rst && (((state_q == S_IDLE) && req_in) ||
                           (state_q == S_ISSUE) || (state_q == S_DRAIN));
   assign busy  = (state_q != S_IDLE);

   assign mem_req   = (state_q == S_ISSUE);
   assign mem_we    = (state_q == S_ISSUE) && req_q.is_wr;
   assign mem_addr  = (state_q == S_ISSUE) ? req_q.base + ADDR_W'(beat_q) : '0;
   assign mem_wdata = (state_q == S_ISSUE) ? beat_word : '0;

   assign done        = (state_q == S_DONE);
   assign rdata_valid = (state_q == S_DONE) && !req_q.is_wr;
   assign rdata       = rdata_q;
   assign wb_idx      = req_q.idx;

endmodule

// File: tb/tb_vec_mem_sequencer.sv
// Directed bench for vec_mem_sequencer: a one-cycle-latency memory model
// answers read beats; each operation is run cycle by cycle and its beats,
// stall count and completion are compared with hand-computed values.
module tb_vec_mem_sequencer;

   localparam int VEC_W  = 192;
   localparam int WORD_W = 32;
   localparam int ADDR_W = 16;
   localparam int IDX_W  = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic              mem_read, mem_write, vector_op;
   logic [ADDR_W-1:0] addr;
   logic [VEC_W-1:0]  wdata;
   logic [IDX_W-1:0]  rd_idx;
   logic              stall, busy, mem_req, mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [WORD_W-1:0] mem_wdata;
   logic              mem_ready;
   logic              mem_rvalid = 1'b0;
   logic [WORD_W-1:0] mem_rdata = '0;
   logic              done, rdata_valid;
   logic [VEC_W-1:0]  rdata;
   logic [IDX_W-1:0]  wb_idx;

   vec_mem_sequencer #(
      .VEC_W(VEC_W), .WORD_W(WORD_W), .ADDR_W(ADDR_W), .IDX_W(IDX_W)
   ) dut (
      .clk(clk), .rst(rst),
      .mem_read(mem_read), .mem_write(mem_write), .vector_op(vector_op),
      .addr(addr), .wdata(wdata), .rd_idx(rd_idx),
      .stall(stall), .busy(busy),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
      .done(done), .rdata_valid(rdata_valid), .rdata(rdata), .wb_idx(wb_idx)
   );

   always #5 clk = ~clk;

   // Memory model: read data = rd_val0 + (beat address - rd_base).
   logic [15:0] rd_base = '0;
   logic [31:0] rd_val0 = '0;
   always @(posedge clk) begin
      mem_rvalid <= mem_req & mem_ready & ~mem_we;
      mem_rdata  <= rd_val0 + 32'(mem_addr - rd_base);
   end

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Per-operation observations.
   int          done_cyc, stall_cnt, nacc;
   logic [15:0] acc_addr [8];
   logic [31:0] acc_data [8];
   logic        acc_we   [8];
   logic        got_rv;
   logic [191:0] got_rdata;
   logic [3:0]  got_idx;

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   // Called at posedge+1 of an idle cycle; that cycle is cycle 1 (accept).
   // bp holds mem_ready low 3 cycles on beats 2 and 4; abort_after stops
   // watching once that many beats have been accepted.
   task automatic run_op(input logic rd, input logic wr, input logic vec,
                         input logic [15:0] a, input logic [191:0] wd,
                         input logic [3:0] idx, input bit bp, input int abort_after);
      int hold = 0;
      done_cyc = 0; stall_cnt = 0; nacc = 0; got_rv = 1'b0; got_rdata = '0; got_idx = '0;
      mem_read = rd; mem_write = wr; vector_op = vec; addr = a; wdata = wd; rd_idx = idx;
      mem_ready = 1'b1;
      for (int cyc = 1; cyc <= 40; cyc++) begin
         if (cyc > 1) begin
            @(posedge clk);
            #1;
            // Scramble stage inputs: only latched values may be used.
            mem_read = 1'b0; mem_write = 1'b0; vector_op = ~vec;
            addr = ~a; wdata = ~wd; rd_idx = ~idx;
            mem_ready = !(bp && (nacc == 2 || nacc == 4) && hold < 3);
            if (!mem_ready) hold++;
         end
         #1;
         if (stall) stall_cnt++;
         if (mem_req && !mem_ready) begin
            chk("hold_addr", mem_addr, 16'(a + 16'(nacc)));
            chk("hold_wdata", mem_wdata, wd[nacc*32 +: 32]);
         end
         if (mem_req && mem_ready) begin
            if (nacc < 8) begin
               acc_addr[nacc] = mem_addr;
               acc_data[nacc] = mem_wdata;
               acc_we[nacc]   = mem_we;
            end
            nacc++;
            hold = 0;
         end
         if (done) begin
            done_cyc = cyc; got_rv = rdata_valid; got_rdata = rdata; got_idx = wb_idx;
            break;
         end
         if (abort_after != 0 && nacc == abort_after) begin
            done_cyc = cyc;
            break;
         end
      end
      if (done_cyc == 0) chk("timeout", done, 1'b1);
      mem_ready = 1'b1;
   endtask

   logic [191:0] wd;
   logic [15:0]  wrap_a [6];

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      // Reset with a request pending: every output must read zero.
      rst = 1'b1; mem_read = 1'b1; mem_write = 1'b1; vector_op = 1'b1;
      addr = 16'h1234; wdata = '1; rd_idx = 4'hF; mem_ready = 1'b1;
      #12;
      chk("rst_stall", stall, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_mem_req", mem_req, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_rdata", rdata, 192'h0);
      chk("rst_wb_idx", wb_idx, 4'h0);
      mem_read = 1'b0; mem_write = 1'b0;
      @(posedge clk); #1 rst = 1'b0;
      next_cycle();

      // Vector store at 0x0010, data 1..6.
      for (int i = 0; i < 6; i++) wd[i*32 +: 32] = 32'(i + 1);
      run_op(1'b0, 1'b1, 1'b1, 16'h0010, wd, 4'h3, 1'b0, 0);
      chk("vst_done_cyc", done_cyc, 8);
      chk("vst_stall", stall_cnt, 7);
      chk("vst_nbeats", nacc, 6);
      for (int i = 0; i < 6; i++) begin
         chk("vst_addr", acc_addr[i], 16'h0010 + 16'(i));
         chk("vst_data", acc_data[i], 32'(i + 1));
         chk("vst_we", acc_we[i], 1'b1);
      end
      chk("vst_rvalid", got_rv, 1'b0);
      next_cycle();
      next_cycle();

      // Vector load at 0x0100, memory returns A0+i.
      rd_base = 16'h0100; rd_val0 = 32'hA0;
      run_op(1'b1, 1'b0, 1'b1, 16'h0100, {6{32'h5555AAAA}}, 4'h9, 1'b0, 0);
      chk("vld_done_cyc", done_cyc, 9);
      chk("vld_stall", stall_cnt, 8);
      chk("vld_nbeats", nacc, 6);
      for (int i = 0; i < 6; i++) chk("vld_we", acc_we[i], 1'b0);
      chk("vld_rvalid", got_rv, 1'b1);
      chk("vld_rdata", got_rdata,
          {32'hA5, 32'hA4, 32'hA3, 32'hA2, 32'hA1, 32'hA0});
      chk("vld_wb_idx", got_idx, 4'h9);
      next_cycle();
      #1;
      chk("vld_idle_done", done, 1'b0);
      chk("vld_hold_rdata", rdata, {32'hA5, 32'hA4, 32'hA3, 32'hA2, 32'hA1, 32'hA0});
      chk("vld_hold_idx", wb_idx, 4'h9);
      next_cycle();

      // Back-pressure: ready low 3 cycles on beats 2 and 4.
      for (int i = 0; i < 6; i++) wd[i*32 +: 32] = 32'hC0DE0000 + 32'(i);
      run_op(1'b0, 1'b1, 1'b1, 16'h0020, wd, 4'h1, 1'b1, 0);
      chk("bp_done_cyc", done_cyc, 14);
      chk("bp_stall", stall_cnt, 13);
      chk("bp_nbeats", nacc, 6);
      for (int i = 0; i < 6; i++) begin
         chk("bp_addr", acc_addr[i], 16'h0020 + 16'(i));
         chk("bp_data", acc_data[i], 32'hC0DE0000 + 32'(i));
      end
      next_cycle();
      next_cycle();

      // Scalar load at 0xFFFF.
      rd_base = 16'hFFFF; rd_val0 = 32'hDEADBEEF;
      run_op(1'b1, 1'b0, 1'b0, 16'hFFFF, {6{32'h12345678}}, 4'h5, 1'b0, 0);
      chk("sld_done_cyc", done_cyc, 4);
      chk("sld_stall", stall_cnt, 3);
      chk("sld_nbeats", nacc, 1);
      chk("sld_addr", acc_addr[0], 16'hFFFF);
      chk("sld_rdata", got_rdata, 192'hDEADBEEF);
      chk("sld_rvalid", got_rv, 1'b1);
      chk("sld_wb_idx", got_idx, 4'h5);
      next_cycle();
      next_cycle();

      // Vector store wrapping past 0xFFFF.
      wrap_a = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001, 16'h0002, 16'h0003};
      for (int i = 0; i < 6; i++) wd[i*32 +: 32] = 32'h5000 + 32'(i);
      run_op(1'b0, 1'b1, 1'b1, 16'hFFFE, wd, 4'h2, 1'b0, 0);
      chk("wrap_done_cyc", done_cyc, 8);
      for (int i = 0; i < 6; i++) begin
         chk("wrap_addr", acc_addr[i], wrap_a[i]);
         chk("wrap_data", acc_data[i], 32'h5000 + 32'(i));
      end
      next_cycle();
      next_cycle();

      // Reset in the middle of a vector load after 3 accepted beats.
      rd_base = 16'h0100; rd_val0 = 32'hA0;
      run_op(1'b1, 1'b0, 1'b1, 16'h0100, '0, 4'h7, 1'b0, 3);
      chk("abort_nbeats", nacc, 3);
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("mid_rst_stall", stall, 1'b0);
      chk("mid_rst_busy", busy, 1'b0);
      chk("mid_rst_mem_req", mem_req, 1'b0);
      chk("mid_rst_mem_we", mem_we, 1'b0);
      chk("mid_rst_mem_addr", mem_addr, 16'h0);
      chk("mid_rst_mem_wdata", mem_wdata, 32'h0);
      chk("mid_rst_done", done, 1'b0);
      chk("mid_rst_rvalid", rdata_valid, 1'b0);
      chk("mid_rst_rdata", rdata, 192'h0);
      chk("mid_rst_wb_idx", wb_idx, 4'h0);
      #1 rst = 1'b0;
      @(posedge clk);
      #2;
      chk("late_rvalid_busy", busy, 1'b0);
      chk("late_rvalid_rdata", rdata, 192'h0);
      next_cycle();
      wd = '0; wd[31:0] = 32'h12345678;
      run_op(1'b0, 1'b1, 1'b0, 16'h0055, wd, 4'h2, 1'b0, 0);
      chk("post_rst_done_cyc", done_cyc, 3);
      chk("post_rst_stall", stall_cnt, 2);
      chk("post_rst_nbeats", nacc, 1);
      chk("post_rst_addr", acc_addr[0], 16'h0055);
      chk("post_rst_data", acc_data[0], 32'h12345678);
      chk("post_rst_we", acc_we[0], 1'b1);
      next_cycle();
      next_cycle();

      // Read and write together: treated as a write.
      wd = '0; wd[31:0] = 32'hCAFEF00D;
      run_op(1'b1, 1'b1, 1'b0, 16'h0042, wd, 4'hA, 1'b0, 0);
      chk("rw_done_cyc", done_cyc, 3);
      chk("rw_nbeats", nacc, 1);
      chk("rw_we", acc_we[0], 1'b1);
      chk("rw_data", acc_data[0], 32'hCAFEF00D);
      chk("rw_rvalid", got_rv, 1'b0);
      next_cycle();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
